rom_load_arbiter: RTL

ROM_LOAD_ARBITER -- requirements
Module: rom_load_arbiter

---
 rtl/rom_load_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter
//
// Streams a ROM image from a byte loader into block RAM while the console is
// halted and held in reset. After the last byte it releases the halt, keeps the
// console in reset for RST_CYCLES clocks, and then hands the RAM port to the
// console bus. A load_start pulse restarts the load from address 0 at any time.
//
// Ports
//   clk, rst          : clock; asynchronous active-low reset
//   load_start        : one-cycle request to (re)start an image load
//   load_valid/data   : loader byte stream; load_ready is its acceptance
//   gb_addr, gb_rd    : console read request; gb_din is the returned data
//   mem_*             : block-RAM port (one-cycle read latency on mem_rdata)
//   gb_halt, gb_rst   : console clock gate and console reset (active-high)
//   busy              : high whenever the console does not own the RAM

module rom_load_arbiter #(
    parameter int unsigned ROM_SIZE   = 32768,
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    input  logic [15:0] gb_addr,
    input  logic        gb_rd,
    output logic [7:0]  gb_din,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_en,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        gb_halt,
    output logic        gb_rst,
    output logic        busy
);

    typedef enum logic [1:0] {
        StLoad,
        StRelease,
        StRun
    } state_e;

    localparam logic [16:0] LastAddr = 17'(ROM_SIZE - 1);
    localparam logic [7:0]  LastDly  = 8'(RST_CYCLES - 1);

    state_e      r_state;
    logic [16:0] r_cnt;
    logic [7:0]  r_dly;
    logic        r_gb_halt;
    logic        r_gb_rst;
    logic        r_busy;

    state_e      w_state_d;
    logic [16:0] w_cnt_d;
    logic [7:0]  w_dly_d;
    logic        w_hs;

    // Next-state logic and the combinational RAM-port mux.
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_dly_d    = r_dly;
        w_hs       = 1'b0;
        load_ready = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        gb_din     = 8'hFF;

        unique case (r_state)
            StLoad: begin
                // Reset forces StLoad asynchronously; gating with rst keeps the
                // loader from writing while reset is still held.
                load_ready = rst;
                mem_addr   = r_cnt[15:0];
                mem_wdata  = load_data;
                // A restart wins over a coincident handshake.
                w_hs       = load_valid && load_ready && !load_start;
                if (load_start) begin
                    w_cnt_d = '0;
                end else if (w_hs) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    if (r_cnt == LastAddr) begin
                        w_cnt_d   = '0;
                        w_dly_d   = '0;
                        w_state_d = StRelease;
                    end else begin
                        w_cnt_d = r_cnt + 17'd1;
                    end
                end
            end
            StRelease: begin
                if (load_start) begin
                    w_state_d = StLoad;
                    w_cnt_d   = '0;
                    w_dly_d   = '0;
                end else if (r_dly == LastDly) begin
                    w_state_d = StRun;
                    w_dly_d   = '0;
                end else begin
                    w_dly_d = r_dly + 8'd1;
                end
            end
            StRun: begin
                mem_addr = gb_addr;
                mem_en   = gb_rd;
                gb_din   = mem_rdata;
                if (load_start) begin
                    w_state_d = StLoad;
                    w_cnt_d   = '0;
                    w_dly_d   = '0;
                end
            end
            default: begin
                w_state_d = StLoad;
                w_cnt_d   = '0;
                w_dly_d   = '0;
            end
        endcase
    end

    // Console control outputs are registered from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StLoad;
            r_cnt     <= '0;
            r_dly     <= '0;
            r_gb_halt <= 1'b1;
            r_gb_rst  <= 1'b1;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_dly     <= w_dly_d;
            r_gb_halt <= (w_state_d == StLoad);
            r_gb_rst  <= (w_state_d != StRun);
            r_busy    <= (w_state_d != StRun);
        end
    end

    assign gb_halt = r_gb_halt;
    assign gb_rst  = r_gb_rst;
    assign busy    = r_busy;

endmodule
